// File: rtl/pll_lock_rst_seq.sv
// Reset sequencer for the PLL clock domain: synchronises lock/button, pulses the lock-detector
// restart, releases sys_rst_n after stable lock. Optional WAIT_LOCK timeout: PLL_LOCK_TIMEOUT_EN.
module pll_lock_rst_seq #(
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned LOSS_CNT_W     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  btn_rst_n,
  output logic                  locked_stdy_rst,
  output logic                  sys_rst_n,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 1)  begin : g_bad_stable $error("STABLE_CYCLES must be >= 1"); end
  if (HOLD_CYCLES < 1)    begin : g_bad_hold   $error("HOLD_CYCLES must be >= 1"); end
  if (SYNC_STAGES < 2)    begin : g_bad_sync   $error("SYNC_STAGES must be >= 2"); end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to     $error("TIMEOUT_CYCLES must be >= 1"); end

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  lock_sync_q, lock_sync_d;
  logic [SYNC_STAGES-1:0]  btn_sync_q, btn_sync_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [STAB_W-1:0]       stab_cnt_q, stab_cnt_d;
  logic [LOSS_CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic                    lock_s, btn_s, go;

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign btn_s  = btn_sync_q[SYNC_STAGES-1];
  assign go     = lock_s & btn_s;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stab_cnt_d  = stab_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], btn_rst_n};
`ifdef PLL_LOCK_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = WAIT_LOCK;
`ifdef PLL_LOCK_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (go) begin
          state_d    = STABLE;
          stab_cnt_d = '0;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      STABLE: begin
        // Any gap in go restarts the whole stability window from WAIT_LOCK.
        if (!go) begin
          state_d    = WAIT_LOCK;
          stab_cnt_d = '0;
`ifdef PLL_LOCK_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d = RUN;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      RUN: begin
        // Lock loss takes priority over a simultaneous button press so it is always counted.
        if (!lock_s) begin
          if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else if (!btn_s) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      lock_sync_q <= '0;
      btn_sync_q  <= '0;
      hold_cnt_q  <= '0;
      stab_cnt_q  <= '0;
      loss_cnt_q  <= '0;
`ifdef PLL_LOCK_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lock_sync_q <= lock_sync_d;
      btn_sync_q  <= btn_sync_d;
      hold_cnt_q  <= hold_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
`ifdef PLL_LOCK_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign locked_stdy_rst = (state_q == IDLE);
  assign ready           = (state_q == RUN);
  assign sys_rst_n       = (state_q == RUN);
  assign loss_count      = loss_cnt_q;
  assign state           = state_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed bench for pll_lock_rst_seq with STABLE=8, HOLD=4, SYNC=2, TIMEOUT=32.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pll_lock_rst_seq;

  localparam int LIMIT = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       btn_rst_n;
  logic       locked_stdy_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] loss_count;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int n;

  pll_lock_rst_seq #(
    .STABLE_CYCLES (8),
    .HOLD_CYCLES   (4),
    .SYNC_STAGES   (2),
    .LOSS_CNT_W    (8),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .btn_rst_n      (btn_rst_n),
    .locked_stdy_rst(locked_stdy_rst),
    .sys_rst_n      (sys_rst_n),
    .ready          (ready),
    .loss_count     (loss_count),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until the selected output (0: sys_rst_n, 1: locked_stdy_rst) reaches level.
  task automatic wait_until(input int sel, input logic level, output int cnt);
    logic v;
    cnt = 0;
    do begin
      tick();
      cnt++;
      v = (sel == 0) ? sys_rst_n : locked_stdy_rst;
    end while (v !== level && cnt < LIMIT);
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    btn_rst_n  = 1'b1;
    repeat (3) tick();
    check("rst_state", state, 0);
    check("rst_lsr", locked_stdy_rst, 1);
    check("rst_sys_rst_n", sys_rst_n, 0);
    check("rst_ready", ready, 0);
    check("rst_loss", loss_count, 0);

    // Hold pulse: exactly 4 cycles after release.
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("hold_lsr_high", locked_stdy_rst, 1);
    end
    tick();
    check("hold_lsr_low", locked_stdy_rst, 0);
    check("hold_state", state, 1);
    check("hold_sys_rst_n", sys_rst_n, 0);
    repeat (5) tick();
    check("wait_state", state, 1);

    // Acquire: 2 sync + 1 + 8 = 11 edges.
    pll_locked = 1'b1;
    wait_until(0, 1'b1, n);
    check("acq_latency", n, 11);
    check("acq_ready", ready, 1);
    check("acq_state", state, 3);
    check("acq_loss", loss_count, 0);

    // Loss in RUN: falls 3 edges later, then 4-cycle restart pulse.
    pll_locked = 1'b0;
    wait_until(0, 1'b0, n);
    check("loss_latency", n, 3);
    check("loss_count1", loss_count, 1);
    check("loss_lsr", locked_stdy_rst, 1);
    wait_until(1, 1'b0, n);
    check("loss_pulse_len", n, 4);
    check("loss_wait_state", state, 1);

    // Glitch 5 cycles into STABLE.
    pll_locked = 1'b1;
    repeat (3) tick();
    check("glitch_stable", state, 2);
    repeat (5) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    check("glitch_still_stable", state, 2);
    tick();
    check("glitch_back_wait", state, 1);
    wait_until(0, 1'b1, n);
    check("glitch_rise", n + 2, 11);
    check("glitch_loss", loss_count, 1);

    // Button alone: back to IDLE, no count.
    btn_rst_n = 1'b0;
    wait_until(0, 1'b0, n);
    check("btn_latency", n, 3);
    check("btn_state", state, 0);
    check("btn_loss", loss_count, 1);
    btn_rst_n = 1'b1;
    wait_until(0, 1'b1, n);
    check("btn_reacq", n, 13);

    // Simultaneous button and lock drop counts as loss.
    btn_rst_n  = 1'b0;
    pll_locked = 1'b0;
    wait_until(0, 1'b0, n);
    check("both_latency", n, 3);
    check("both_loss", loss_count, 2);
    btn_rst_n  = 1'b1;
    pll_locked = 1'b1;
    wait_until(0, 1'b1, n);
    check("both_reacq", n, 13);

    // Saturation: 300 more losses from 2 must stop at 255.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      wait_until(0, 1'b0, n);
      check("sat_fall", sys_rst_n, 0);
      pll_locked = 1'b1;
      wait_until(0, 1'b1, n);
      check("sat_rise", sys_rst_n, 1);
    end
    check("sat_loss", loss_count, 255);

    // Reset from RUN clears everything, including loss_count.
    rst        = 1'b1;
    pll_locked = 1'b0;
    tick();
    check("rerst_state", state, 0);
    check("rerst_loss", loss_count, 0);
    check("rerst_sys_rst_n", sys_rst_n, 0);
    rst = 1'b0;
    repeat (4) tick();
    check("rerst_wait", state, 1);

`ifdef PLL_LOCK_TIMEOUT_EN
    wait_until(1, 1'b1, n);
    check("timeout_latency", n, 32);
    check("timeout_state", state, 0);
    check("timeout_loss", loss_count, 0);
`else
    repeat (100) tick();
    check("no_timeout_state", state, 1);
    check("no_timeout_lsr", locked_stdy_rst, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
